// File: rtl/data_load_sequencer_pkg.sv
// Shared encodings for the data-register load sequencer: access sizes,
// DR function selects and FSM states.
package data_load_sequencer_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [1:0] DR_LOAD_SEXT = 2'b00;
  localparam logic [1:0] DR_LOAD_ZEXT = 2'b01;
  localparam logic [1:0] DR_SHL_INS   = 2'b10;
  localparam logic [1:0] DR_SHR_INS   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // Index of the last byte of an access (N-1); seeds the issue down-counter.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      SZ_HALF: return 2'd1;
      SZ_WORD: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_load_sequencer.sv
// Reads 1/2/4 bytes from byte memory and steers DR's I/E/FunSel so DR ends
// up with the big-endian, sign- or zero-extended value.
//
// state    | meaning
// ST_IDLE  | waiting for Start; illegal size pulses Err
// ST_ISSUE | one memory read per cycle, consuming the previous byte
// ST_DRAIN | no read; consume the final byte
// ST_FIN   | Done pulse, DR holds the result
module data_load_sequencer
  import data_load_sequencer_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [1:0]        Size,
  input  logic              Signed,
  input  logic [7:0]        MemData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemCS,
  output logic [7:0]        DR_I,
  output logic              DR_E,
  output logic [1:0]        DR_FunSel,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_cs_q, mem_cs_d;
  logic              dr_e_q, dr_e_d;
  logic [1:0]        funsel_q, funsel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        remain_q, remain_d;
  logic              first_q, first_d;
  logic              sext_q, sext_d;

  // Outputs are registered one cycle ahead so DR_E/FunSel line up with
  // MemData, which arrives a cycle after the address.
  always_comb begin
    state_d    = state_q;
    mem_addr_d = mem_addr_q;
    mem_cs_d   = 1'b0;
    dr_e_d     = 1'b0;
    funsel_d   = DR_LOAD_SEXT;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    remain_d   = remain_q;
    first_d    = first_q;
    sext_d     = sext_q;

    case (state_q)
      ST_IDLE: begin
        if (Start && Size == SZ_ILLEGAL) begin
          err_d = 1'b1;
        end else if (Start) begin
          state_d    = ST_ISSUE;
          mem_cs_d   = 1'b1;
          mem_addr_d = Addr;
          remain_d   = last_index(Size);
          first_d    = 1'b1;
          sext_d     = Signed && (Size != SZ_WORD);
          busy_d     = 1'b1;
        end
      end
      ST_ISSUE: begin
        busy_d   = 1'b1;
        dr_e_d   = 1'b1;
        first_d  = 1'b0;
        funsel_d = first_q ? (sext_q ? DR_LOAD_SEXT : DR_LOAD_ZEXT) : DR_SHL_INS;
        if (remain_q == 2'd0) begin
          state_d = ST_DRAIN;
        end else begin
          mem_cs_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
          remain_d   = remain_q - 2'd1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_FIN;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      mem_cs_q   <= 1'b0;
      dr_e_q     <= 1'b0;
      funsel_q   <= DR_LOAD_SEXT;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      remain_q   <= 2'd0;
      first_q    <= 1'b0;
      sext_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_cs_q   <= mem_cs_d;
      dr_e_q     <= dr_e_d;
      funsel_q   <= funsel_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      remain_q   <= remain_d;
      first_q    <= first_d;
      sext_q     <= sext_d;
    end
  end

  assign MemAddr   = mem_addr_q;
  assign MemCS     = mem_cs_q;
  assign DR_I      = MemData;
  assign DR_E      = dr_e_q;
  assign DR_FunSel = funsel_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Err       = err_q;

endmodule

// File: tb/tb_data_load_sequencer.sv
// Bench for data_load_sequencer: byte memory with 1-cycle read latency, a
// 32-bit DR downstream, and a reference model built from the byte layout.
module tb_data_load_sequencer;

  logic        Clock, Reset, Start, Signed;
  logic [15:0] Addr, MemAddr;
  logic [1:0]  Size, DR_FunSel;
  logic [7:0]  MemData, DR_I;
  logic        MemCS, DR_E, Busy, Done, Err;

  logic [7:0]  mem [0:65535];
  logic [31:0] dr;
  int          checks = 0;
  int          errors = 0;

  data_load_sequencer #(.ADDR_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Addr(Addr), .Size(Size),
    .Signed(Signed), .MemData(MemData), .MemAddr(MemAddr), .MemCS(MemCS),
    .DR_I(DR_I), .DR_E(DR_E), .DR_FunSel(DR_FunSel), .Busy(Busy),
    .Done(Done), .Err(Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (MemCS) MemData <= mem[MemAddr];
  end

  always @(posedge Clock) begin
    if (DR_E) begin
      case (DR_FunSel)
        2'b00:   dr <= {{24{DR_I[7]}}, DR_I};
        2'b01:   dr <= {24'h0, DR_I};
        2'b10:   dr <= {dr[23:0], DR_I};
        default: dr <= {DR_I, dr[31:8]};
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Big-endian concatenation of n bytes from a, extended from byte 0 bit 7.
  function automatic logic [31:0] exp_load(input logic [15:0] a, input int n, input bit sgn);
    logic [31:0] v;
    logic [15:0] ai;
    v = 32'h0;
    for (int i = 0; i < n; i++) begin
      ai = a + 16'(i);
      v  = (v << 8) | {24'h0, mem[ai]};
    end
    if (sgn && n < 4 && mem[a][7]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic run_load(input logic [15:0] a, input logic [1:0] sz, input bit sgn, input bit poke);
    int          n;
    logic [31:0] exp;
    logic [1:0]  fs0;
    n   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    exp = exp_load(a, n, sgn);
    fs0 = (sgn && n < 4) ? 2'b00 : 2'b01;
    Start = 1'b1; Addr = a; Size = sz; Signed = sgn;
    tick();
    Addr = 16'($urandom); Size = 2'($urandom_range(0, 3)); Signed = 1'($urandom);
    for (int c = 1; c <= n + 2; c++) begin
      Start = (poke && c == 2);
      check("mem_cs", 32'(MemCS), 32'(c <= n));
      if (c <= n) check("mem_addr", 32'(MemAddr), 32'(16'(a + 16'(c - 1))));
      check("busy", 32'(Busy), 32'(c <= n + 1));
      check("done", 32'(Done), 32'(c == n + 2));
      check("dr_e", 32'(DR_E), 32'(c >= 2 && c <= n + 1));
      if (c >= 2 && c <= n + 1) check("funsel", 32'(DR_FunSel), 32'((c == 2) ? fs0 : 2'b10));
      if (c == 2) check("dr_i", 32'(DR_I), 32'(MemData));
      if (c == n + 2) check("dr_value", dr, exp);
      tick();
    end
    Start = 1'b0;
    check("done_after", 32'(Done), 32'd0);
    check("busy_after", 32'(Busy), 32'd0);
  endtask

  initial begin
    int dones;
    Reset = 1'b1; Start = 1'b0; Addr = 16'h0; Size = 2'b00; Signed = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0010] = 8'h8A; mem[16'h0011] = 8'h12;
    mem[16'h0012] = 8'h34; mem[16'h0013] = 8'h56;
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22;
    mem[16'h0000] = 8'h33; mem[16'h0001] = 8'h44;
    tick();
    tick();
    check("rst_out", {MemAddr, 6'h0, MemCS, DR_E, DR_FunSel, Busy, Done, Err, 3'h0}, 32'h0);
    Reset = 1'b0;
    tick();

    run_load(16'h0010, 2'b10, 1'b0, 1'b0);
    check("word", dr, 32'h8A12_3456);
    run_load(16'h0010, 2'b00, 1'b1, 1'b0);
    check("byte_s", dr, 32'hFFFF_FF8A);
    run_load(16'h0010, 2'b00, 1'b0, 1'b0);
    check("byte_u", dr, 32'h0000_008A);
    run_load(16'h0010, 2'b01, 1'b1, 1'b0);
    check("half_s", dr, 32'hFFFF_8A12);
    run_load(16'h0011, 2'b01, 1'b1, 1'b0);
    check("half_pos", dr, 32'h0000_1234);
    run_load(16'hFFFE, 2'b10, 1'b1, 1'b0);
    check("wrap", dr, 32'h1122_3344);
    run_load(16'h0010, 2'b10, 1'b0, 1'b1);
    check("poke_word", dr, 32'h8A12_3456);

    Start = 1'b1; Addr = 16'h0010; Size = 2'b11; Signed = 1'b0;
    tick();
    Start = 1'b0;
    check("err", 32'(Err), 32'd1);
    check("err_cs", {31'h0, MemCS}, 32'h0);
    check("err_dre", {31'h0, DR_E}, 32'h0);
    check("err_busy", {31'h0, Busy}, 32'h0);
    tick();
    check("err_pulse", 32'(Err), 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (Done || Busy || MemCS) dones++;
      tick();
    end
    check("err_quiet", 32'(dones), 32'd0);

    Start = 1'b1; Addr = 16'h0010; Size = 2'b10; Signed = 1'b0;
    tick();
    Start = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    check("mid_rst", {MemAddr, 6'h0, MemCS, DR_E, DR_FunSel, Busy, Done, Err, 3'h0}, 32'h0);
    Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (Done) dones++;
      tick();
    end
    check("mid_rst_nodone", 32'(dones), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a;
      a = (i % 4 == 0) ? 16'(16'hFFFC + 16'($urandom_range(0, 3))) : 16'($urandom);
      run_load(a, 2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
